ddr3_port_arbiter: RTL and testbench

- Multi-client arbiter for the single DDR3 master port of the Canny pipeline (grayscale, hysteresis and future stages).
- Each client sees the same address/rd_en/wr_en/complete handshake it would see on a direct connection.
- The arbiter serialises client transactions onto the memory port in round-robin order, one outstanding transaction at a time, with a watchdog timeout.

---
 rtl/ddr3_arb_pkg.sv | 19 +
 rtl/rr_select.sv | 33 +++
 rtl/ddr3_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared types and default widths for the DDR3 port arbiter and its helpers.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 128;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority encoder: picks the first requester after the last granted
// index, wrapping from NUM_CLIENTS-1 back to 0.
module rr_select #(
    parameter int NUM_CLIENTS = 2
) (
    input  logic [NUM_CLIENTS-1:0]         i_req,
    input  logic [$clog2(NUM_CLIENTS)-1:0] i_last_grant,
    output logic [$clog2(NUM_CLIENTS)-1:0] o_grant,
    output logic                           o_valid
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    logic [IDX_W-1:0] w_idx;

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        // Walk from the farthest offset to the nearest; the last hit wins,
        // so the closest requester after i_last_grant takes priority.
        for (int off = NUM_CLIENTS; off >= 1; off--) begin
            w_idx = IDX_W'((int'(i_last_grant) + off) % NUM_CLIENTS);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 master port between pipeline stages,
// one outstanding transaction at a time, with a completion watchdog.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
    input  logic [NUM_CLIENTS-1:0]            cl_rd_en,
    input  logic [NUM_CLIENTS-1:0]            cl_wr_en,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_write_data,
    output logic [DATA_WIDTH-1:0]             cl_read_data,
    output logic [NUM_CLIENTS-1:0]            cl_read_complete,
    output logic [NUM_CLIENTS-1:0]            cl_write_complete,
    output logic [ADDR_WIDTH-1:0]             sdram_address,
    output logic                              rd_en,
    output logic                              wr_en,
    output logic [DATA_WIDTH-1:0]             write_data_input,
    input  logic [DATA_WIDTH-1:0]             read_data,
    input  logic                              read_complete,
    input  logic                              write_complete,
    output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int                IDX_W       = $clog2(NUM_CLIENTS);
    localparam int                WD_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_CLIENT = IDX_W'(NUM_CLIENTS - 1);

    arb_state_t              r_state;
    arb_op_t                 r_op;
    logic [IDX_W-1:0]        r_last_grant;
    logic [IDX_W-1:0]        r_grant_id;
    logic [ADDR_WIDTH-1:0]   r_lat_addr;
    logic [DATA_WIDTH-1:0]   r_lat_wdata;
    logic [ADDR_WIDTH-1:0]   r_sdram_addr;
    logic [DATA_WIDTH-1:0]   r_wdata_out;
    logic                    r_rd_en;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [NUM_CLIENTS-1:0]  r_rd_cmp;
    logic [NUM_CLIENTS-1:0]  r_wr_cmp;
    logic                    r_busy;
    logic                    r_timeout;
    logic [WD_W-1:0]         r_wd_cnt;

    logic [NUM_CLIENTS-1:0]  w_req;
    logic [IDX_W-1:0]        w_sel;
    logic                    w_sel_valid;
    logic                    w_done;
    logic                    w_expire;

    assign w_req    = cl_rd_en | cl_wr_en;
    // Only a completion of the latched operation type ends the transaction.
    assign w_done   = (r_op == OP_RD) ? read_complete : write_complete;
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST);

    rr_select #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr_select (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_sel),
        .o_valid      (w_sel_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_op         <= OP_RD;
            r_last_grant <= LAST_CLIENT;
            r_grant_id   <= '0;
            // NOTE: the wide data registers are reset too because they drive
            // outputs that must read zero while reset is held.
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_sdram_addr <= '0;
            r_wdata_out  <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_rd_data    <= '0;
            r_rd_cmp     <= '0;
            r_wr_cmp     <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_wd_cnt     <= '0;
        end else begin
            r_rd_cmp <= '0;
            r_wr_cmp <= '0;
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                        r_op         <= cl_rd_en[w_sel] ? OP_RD : OP_WR;
                        r_lat_addr   <= cl_address[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_lat_wdata  <= cl_write_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_sdram_addr <= r_lat_addr;
                    r_wdata_out  <= r_lat_wdata;
                    r_rd_en      <= (r_op == OP_RD);
                    r_wr_en      <= (r_op == OP_WR);
                    r_wd_cnt     <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (w_done || w_expire) begin
                        r_rd_en <= 1'b0;
                        r_wr_en <= 1'b0;
                        if (r_op == OP_RD) begin
                            r_rd_data            <= w_done ? read_data : '0;
                            r_rd_cmp[r_grant_id] <= 1'b1;
                        end else begin
                            r_wr_cmp[r_grant_id] <= 1'b1;
                        end
                        if (!w_done) r_timeout <= 1'b1;
                        r_state <= RELEASE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cl_read_data      = r_rd_data;
    assign cl_read_complete  = r_rd_cmp;
    assign cl_write_complete = r_wr_cmp;
    assign sdram_address     = r_sdram_addr;
    assign rd_en             = r_rd_en;
    assign wr_en             = r_wr_en;
    assign write_data_input  = r_wdata_out;
    assign grant_id          = r_grant_id;
    assign busy              = r_busy;
    assign timeout_err       = r_timeout;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: two clients, 16-cycle watchdog, a
// scripted memory responder and hand-computed expectations.
module tb_ddr3_port_arbiter;

    localparam int NC = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 16;

    localparam logic [DW-1:0] DATA_A = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [DW-1:0] DATA_B = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [DW-1:0] DATA_C = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [DW-1:0] WD_C0  = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [DW-1:0] WD_C1  = 128'h1111_1111_1111_1111_1111_1111_1111_1111;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC*AW-1:0]  cl_address;
    logic [NC-1:0]     cl_rd_en;
    logic [NC-1:0]     cl_wr_en;
    logic [NC*DW-1:0]  cl_write_data;
    logic [DW-1:0]     cl_read_data;
    logic [NC-1:0]     cl_read_complete;
    logic [NC-1:0]     cl_write_complete;
    logic [AW-1:0]     sdram_address;
    logic              rd_en;
    logic              wr_en;
    logic [DW-1:0]     write_data_input;
    logic [DW-1:0]     read_data;
    logic              read_complete;
    logic              write_complete;
    logic [0:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    ddr3_port_arbiter #(
        .NUM_CLIENTS    (NC),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cl_address        (cl_address),
        .cl_rd_en          (cl_rd_en),
        .cl_wr_en          (cl_wr_en),
        .cl_write_data     (cl_write_data),
        .cl_read_data      (cl_read_data),
        .cl_read_complete  (cl_read_complete),
        .cl_write_complete (cl_write_complete),
        .sdram_address     (sdram_address),
        .rd_en             (rd_en),
        .wr_en             (wr_en),
        .write_data_input  (write_data_input),
        .read_data         (read_data),
        .read_complete     (read_complete),
        .write_complete    (write_complete),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Waits (bounded) for the memory request, keeps it pending for lat cycles
    // counting how long the request stays high, then pulses the completion.
    task automatic mem_serve(input bit is_rd, input int lat, input logic [DW-1:0] data,
                             output int hi);
        int n;
        n  = 0;
        hi = 0;
        while (((is_rd ? rd_en : wr_en) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        check("mem_en_seen", is_rd ? rd_en : wr_en, 1'b1);
        hi = 1;
        repeat (lat - 1) begin
            tick();
            if ((is_rd ? rd_en : wr_en) === 1'b1) hi++;
        end
        if (is_rd) begin
            read_complete = 1'b1;
            read_data     = data;
        end else begin
            write_complete = 1'b1;
        end
        tick();
        read_complete  = 1'b0;
        write_complete = 1'b0;
        read_data      = 128'hBAD;
        check("mem_en_dropped", {rd_en, wr_en}, 2'b00);
    endtask

    initial begin
        int hi;
        int n;
        cl_address     = '0;
        cl_rd_en       = '0;
        cl_wr_en       = '0;
        cl_write_data  = '0;
        read_data      = '0;
        read_complete  = 1'b0;
        write_complete = 1'b0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check("rst_outputs", {rd_en, wr_en, busy, grant_id, timeout_err}, 5'b0);
        check("rst_completes", {cl_read_complete, cl_write_complete}, 4'b0);
        check("rst_read_data", cl_read_data, '0);
        reset = 1'b1;
        tick();

        // Single read, 5-cycle memory latency
        cl_address[AW-1:0] = 32'h0000_1000;
        cl_rd_en = 2'b01;
        tick();
        check("rd_grant_id", grant_id, 1'b0);
        check("rd_issue_busy_en", {busy, rd_en}, 2'b10);
        mem_serve(1'b1, 5, DATA_A, hi);
        check("rd_en_high_cycles", hi, 5);
        check("rd_complete_pulse", cl_read_complete, 2'b01);
        check("rd_data", cl_read_data, DATA_A);
        check("rd_addr", sdram_address, 32'h0000_1000);
        cl_rd_en = 2'b00;
        tick();
        check("rd_complete_once", cl_read_complete, 2'b00);
        check("rd_idle_busy", busy, 1'b0);
        check("rd_data_hold", cl_read_data, DATA_A);

        // Contention from reset: client 0 reads, client 1 writes
        do_reset();
        cl_address = {32'h0000_3000, 32'h0000_2000};
        cl_write_data[2*DW-1:DW] = WD_C1;
        cl_rd_en = 2'b01;
        cl_wr_en = 2'b10;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                check("cont_release_gap", busy, 1'b0);
                tick();
            end
            check("cont_grant_id", grant_id, k % 2);
            check("cont_busy", busy, 1'b1);
            mem_serve(k % 2 == 0, 3, DATA_C + k, hi);
            if (k % 2 == 0) begin
                check("cont_addr0", sdram_address, 32'h0000_2000);
                check("cont_rd_complete", cl_read_complete, 2'b01);
                check("cont_rd_data", cl_read_data, DATA_C + k);
            end else begin
                check("cont_addr1", sdram_address, 32'h0000_3000);
                check("cont_wr_complete", cl_write_complete, 2'b10);
                check("cont_wdata", write_data_input, WD_C1);
            end
        end
        cl_rd_en = 2'b00;
        cl_wr_en = 2'b00;
        tick();
        tick();
        check("cont_idle", busy, 1'b0);

        // Same client holds read and write: read first, write afterwards
        cl_address[2*AW-1:AW] = 32'h0000_4000;
        cl_rd_en = 2'b10;
        cl_wr_en = 2'b10;
        tick();
        check("rw_grant_rd", grant_id, 1'b1);
        mem_serve(1'b1, 3, DATA_B, hi);
        check("rw_rd_complete", cl_read_complete, 2'b10);
        check("rw_no_wr_yet", cl_write_complete, 2'b00);
        check("rw_rd_data", cl_read_data, DATA_B);
        cl_rd_en = 2'b00;
        tick();
        tick();
        check("rw_grant_wr", {busy, grant_id}, 2'b11);
        mem_serve(1'b0, 2, '0, hi);
        check("rw_wr_complete", cl_write_complete, 2'b10);
        check("rw_no_rd", cl_read_complete, 2'b00);
        cl_wr_en = 2'b00;
        tick();
        tick();

        // Spurious completions: write_complete in IDLE, read_complete during a write
        write_complete = 1'b1;
        tick();
        write_complete = 1'b0;
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_pulses", {cl_read_complete, cl_write_complete}, 4'b0);
        cl_write_data[DW-1:0] = WD_C0;
        cl_wr_en = 2'b01;
        tick();
        tick();
        check("spur_wr_en", wr_en, 1'b1);
        read_complete = 1'b1;
        read_data     = 128'h5555;
        tick();
        read_complete = 1'b0;
        check("spur_wr_en_held", {busy, wr_en}, 2'b11);
        check("spur_wait_pulses", {cl_read_complete, cl_write_complete}, 4'b0);
        check("spur_rd_data_kept", cl_read_data, DATA_B);
        mem_serve(1'b0, 2, '0, hi);
        check("spur_wr_complete", cl_write_complete, 2'b01);
        check("spur_wdata", write_data_input, WD_C0);
        cl_wr_en = 2'b00;
        tick();
        tick();

        // Watchdog: memory never completes a read from client 1
        cl_address[2*AW-1:AW] = 32'h0000_5000;
        cl_rd_en = 2'b10;
        tick();
        tick();
        check("to_rd_en", rd_en, 1'b1);
        check("to_err_before", timeout_err, 1'b0);
        hi = 1;
        n  = 0;
        while (rd_en === 1'b1 && n < 40) begin
            tick();
            n++;
            if (rd_en === 1'b1) hi++;
        end
        check("to_rd_en_cycles", hi, TO);
        check("to_err_set", timeout_err, 1'b1);
        check("to_complete", cl_read_complete, 2'b10);
        check("to_rd_data_zero", cl_read_data, '0);
        cl_rd_en = 2'b00;
        tick();
        tick();
        cl_wr_en = 2'b01;
        tick();
        check("to_next_grant", {busy, grant_id}, 2'b10);
        mem_serve(1'b0, 2, '0, hi);
        check("to_next_complete", cl_write_complete, 2'b01);
        check("to_err_sticky", timeout_err, 1'b1);
        cl_wr_en = 2'b00;
        tick();
        tick();

        // Asynchronous reset in the middle of a write's WAIT phase
        cl_wr_en = 2'b10;
        tick();
        tick();
        check("rstw_pre", {wr_en, busy, grant_id, timeout_err}, 4'b1111);
        cl_wr_en = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        check("rstw_async", {wr_en, busy, grant_id, timeout_err}, 4'b0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        check("rstw_first_grant", {busy, grant_id}, 2'b10);
        mem_serve(1'b0, 2, '0, hi);
        check("rstw_complete", cl_write_complete, 2'b01);
        check("rstw_wdata", write_data_input, WD_C0);
        cl_wr_en = 2'b00;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
